// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter (8 data bits, 1 stop bit,
// optional even parity bit when UART_TX_PARITY_EN is defined).
// ena acts as a clock enable for the whole tile: with ena low nothing advances.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = 12;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } state_t;

    // Even parity: XOR of all data bits
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic [7:0]      mem [FIFO_DEPTH];
    logic            wr_en_s;
    logic            pop_s;
    logic [7:0]      head_s;

    assign in_ready   = ena && (count_q < DEPTH_C);
    assign wr_en_s    = in_valid && in_ready;
    assign head_s     = mem[rd_ptr_q];
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

    // FIFO storage write port; storage itself is not reset, pointers are
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_s) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    // Transmit FSM: next state, baud counting, bit shifting and head pop
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        pop_s     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (ena) begin
            case (state_q)
                IDLE: begin
                    tx_d = 1'b1;
                    if (count_q != {CW{1'b0}}) begin
                        pop_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                START: begin
                    if (baud_q == {BW{1'b0}}) begin
                        state_d   = DATA;
                        baud_d    = BAUD_LOAD;
                        bit_idx_d = 3'd0;
                        tx_d      = shreg_q[0];
                    end else begin
                        baud_d = baud_q - {{(BW-1){1'b0}}, 1'b1};
                    end
                end
                DATA: begin
                    if (baud_q == {BW{1'b0}}) begin
                        baud_d = BAUD_LOAD;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
                            tx_d    = parity_q;
`else
                            state_d = STOP;
                            tx_d    = 1'b1;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                            shreg_d   = {1'b0, shreg_q[7:1]};
                            tx_d      = shreg_q[1];
                        end
                    end else begin
                        baud_d = baud_q - {{(BW-1){1'b0}}, 1'b1};
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_q == {BW{1'b0}}) begin
                        state_d = STOP;
                        baud_d  = BAUD_LOAD;
                        tx_d    = 1'b1;
                    end else begin
                        baud_d = baud_q - {{(BW-1){1'b0}}, 1'b1};
                    end
                end
`endif
                STOP: begin
                    if (baud_q == {BW{1'b0}}) begin
                        if (count_q != {CW{1'b0}}) begin
                            pop_s = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        baud_d = baud_q - {{(BW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_d = IDLE;
                    baud_d  = {BW{1'b0}};
                    tx_d    = 1'b1;
                end
            endcase
            // Popping the head always starts a fresh frame with the start bit
            if (pop_s) begin
                state_d = START;
                baud_d  = BAUD_LOAD;
                shreg_d = head_s;
                tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                parity_d = even_parity(head_s);
`endif
            end else begin
                shreg_d = shreg_d;
            end
        end else begin
            state_d = state_q;
        end
    end

    // FIFO pointer and occupancy bookkeeping; write and pop together cancel out
    always_comb begin
        wr_ptr_d = wr_en_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s   ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
        busy_d = (state_d != IDLE) || (count_d != {CW{1'b0}});
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            baud_q    <= {BW{1'b0}};
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            count_q   <= {CW{1'b0}};
            wr_ptr_q  <= {PW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenarios for uart_tx_fifo (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Frame length follows UART_TX_PARITY_EN when the bench is built with it.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int total;
    int bad;

    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level for bit slot i of a frame carrying byte b
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        else if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        else if (i == 9) return ^b;
`endif
        else return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        tick(); tick();
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_ena1 got=%b exp=1", in_ready); end
        ena = 1'b0; #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_ena0 got=%b exp=0", in_ready); end
        ena = 1'b1;
        rst_n = 1'b1;
        tick();
        total++; if (tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle tx=%b busy=%b exp tx=1 busy=0", tx, busy); end
    endtask

    task automatic test_single(input logic [7:0] b);
        in_data = b; in_valid = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (fifo_count !== 3'd1 || busy !== 1'b1 || tx !== 1'b1) begin
            bad++; $display("FAIL single_accept count=%0d busy=%b tx=%b exp 1/1/1", fifo_count, busy, tx);
        end
        for (int c = 0; c < FRAME_CYC; c++) begin
            tick();
            total++; if (tx !== frame_bit(b, c / 4)) begin
                bad++; $display("FAIL single_tx byte=%h cyc=%0d got=%b exp=%b", b, c, tx, frame_bit(b, c / 4));
            end
            if (c == 0) begin
                total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL single_pop count=%0d exp=0", fifo_count); end
            end
            if (c == FRAME_CYC - 1) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_last got=%b exp=1", busy); end
            end
        end
        tick();
        total++; if (tx !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL single_end tx=%b busy=%b exp tx=1 busy=0", tx, busy);
        end
    endtask

    task automatic test_full();
        int acc;
        int c;
        int f;
        logic [7:0] eb;
        logic exp_tx;
        acc = 0;
        for (int n = 0; n <= 5 * FRAME_CYC + 3; n++) begin
            if (n < 20) begin
                in_valid = 1'b1;
                in_data  = 8'(acc + 1);
                total++; if (in_ready !== ((n <= 4) ? 1'b1 : 1'b0)) begin
                    bad++; $display("FAIL full_ready n=%0d got=%b exp=%b", n, in_ready, (n <= 4));
                end
                if (n <= 4) acc++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (n <= 4) begin
                total++; if (fifo_count !== 3'((n == 0) ? 1 : n)) begin
                    bad++; $display("FAIL full_count n=%0d got=%0d exp=%0d", n, fifo_count, (n == 0) ? 1 : n);
                end
            end
            if (n >= 1) begin
                c = n - 1;
                if (c < 5 * FRAME_CYC) begin
                    f = c / FRAME_CYC;
                    eb = 8'(f + 1);
                    exp_tx = frame_bit(eb, (c % FRAME_CYC) / 4);
                end else begin
                    exp_tx = 1'b1;
                end
                total++; if (tx !== exp_tx) begin
                    bad++; $display("FAIL full_tx cyc=%0d got=%b exp=%b", c, tx, exp_tx);
                end
            end
        end
        in_valid = 1'b0;
        total++; if (busy !== 1'b0 || fifo_count !== 3'd0) begin
            bad++; $display("FAIL full_end busy=%b count=%0d exp 0/0", busy, fifo_count);
        end
    endtask

    task automatic test_pause();
        int eff;
        logic exp_tx;
        logic [7:0] b;
        b = 8'hB4;
        in_data = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < FRAME_CYC + 7 + 2; c++) begin
            if (c >= 18 && c <= 24) begin
                ena = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
                #1;
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL pause_ready c=%0d got=%b exp=0", c, in_ready); end
            end else begin
                ena = 1'b1; in_valid = 1'b0;
            end
            tick();
            if (c <= 17) eff = c;
            else if (c <= 24) eff = 17;
            else eff = c - 7;
            exp_tx = (eff < FRAME_CYC) ? frame_bit(b, eff / 4) : 1'b1;
            total++; if (tx !== exp_tx) begin
                bad++; $display("FAIL pause_tx cyc=%0d got=%b exp=%b", c, tx, exp_tx);
            end
        end
        ena = 1'b1; in_valid = 1'b0;
        total++; if (busy !== 1'b0 || fifo_count !== 3'd0) begin
            bad++; $display("FAIL pause_end busy=%b count=%0d exp 0/0", busy, fifo_count);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_data = 8'h33; tick();
        in_valid = 1'b0;
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL rmid_queued got=%0d exp=2", fifo_count); end
        for (int i = 0; i < 10; i++) tick();
        total++; if (tx !== frame_bit(8'h11, 3)) begin bad++; $display("FAIL rmid_in_data got=%b exp=%b", tx, frame_bit(8'h11, 3)); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
            bad++; $display("FAIL rmid_after tx=%b busy=%b count=%0d exp 1/0/0", tx, busy, fifo_count);
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            total++; if (tx !== 1'b1 || busy !== 1'b0) begin
                bad++; $display("FAIL rmid_quiet cyc=%0d tx=%b busy=%b exp 1/0", i, tx, busy);
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        test_reset();
        test_single(8'h55);
        test_single(8'h07);
        test_full();
        test_pause();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
